// File: rtl/countdown_timer_pkg.sv
// Shared types and defaults for the countdown timer block.
package countdown_timer_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int unsigned DEFAULT_WIDTH = 4;

endpackage

// File: rtl/countdown_tc_detect.sv
// Expiry detection: a running count at 1 that is enabled and not pre-empted by load.
module countdown_tc_detect
   import countdown_timer_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  state_t           state,
   input  logic             en,
   input  logic             load,
   input  logic [WIDTH-1:0] count,
   output logic             expire
);

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   always_comb begin
      expire = (state == RUN) && en && (count == ONE) && !load;
   end

endmodule

// File: rtl/countdown_timer.sv
// Loadable down-counter with one-shot or auto-reload expiry and a registered terminal-count pulse.
module countdown_timer
   import countdown_timer_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] init,
   input  logic             en,
   input  logic             reload_mode,
   output logic [WIDTH-1:0] out,
   output logic             tc,
   output logic             busy,
   output logic             done
);

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   state_t           state;
   state_t           state_next;
   logic [WIDTH-1:0] reload_val;
   logic [WIDTH-1:0] reload_next;
   logic [WIDTH-1:0] out_next;
   logic             tc_next;
   logic             expire;

   countdown_tc_detect #(
      .WIDTH (WIDTH)
   ) u_tc_detect (
      .state  (state),
      .en     (en),
      .load   (load),
      .count  (out),
      .expire (expire)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         out        <= '0;
         reload_val <= '0;
         tc         <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         state      <= state_next;
         out        <= out_next;
         reload_val <= reload_next;
         tc         <= tc_next;
         busy       <= (state_next == RUN);
         done       <= (state_next == DONE);
      end
   end

   // Priority: load, then expiry, then plain decrement; everything else holds.
   always_comb begin
      state_next  = state;
      out_next    = out;
      reload_next = reload_val;
      tc_next     = 1'b0;
      if (load) begin
         out_next    = init;
         reload_next = init;
         state_next  = (init != '0) ? RUN : IDLE;
      end else if (expire) begin
         tc_next = 1'b1;
         if (reload_mode) begin
            out_next = reload_val;
         end else begin
            out_next   = '0;
            state_next = DONE;
         end
      end else if ((state == RUN) && en && (out > ONE)) begin
         out_next = out - ONE;
      end
   end

endmodule

// File: tb/tb_countdown_timer.sv
// Directed self-checking bench for countdown_timer (WIDTH = 4).
module tb_countdown_timer;

   logic       clk = 1'b0;
   logic       reset;
   logic       load;
   logic [3:0] init;
   logic       en;
   logic       reload_mode;
   logic [3:0] out;
   logic       tc;
   logic       busy;
   logic       done;

   int n_checks = 0;
   int n_fail   = 0;

   countdown_timer #(
      .WIDTH (4)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .load        (load),
      .init        (init),
      .en          (en),
      .reload_mode (reload_mode),
      .out         (out),
      .tc          (tc),
      .busy        (busy),
      .done        (done)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; load = 1'b1; init = 4'd7; en = 1'b1; reload_mode = 1'b1;
      tick();
      n_checks++;
      if ({out, tc, busy, done} !== {4'd0, 1'b0, 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL reset_over_load: out/tc/busy/done got %0d/%b/%b/%b want 0/0/0/0", out, tc, busy, done);
      end
      reset = 1'b0; load = 1'b0; en = 1'b0; reload_mode = 1'b0;
      tick();
      n_checks++;
      if ({out, tc, busy, done} !== {4'd0, 1'b0, 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL reset_idle_hold: out/tc/busy/done got %0d/%b/%b/%b want 0/0/0/0", out, tc, busy, done);
      end
   endtask

   task automatic test_oneshot();
      logic [3:0] eo;
      load = 1'b1; init = 4'd3; en = 1'b0; reload_mode = 1'b0;
      tick();
      n_checks++;
      if ({out, tc, busy, done} !== {4'd3, 1'b0, 1'b1, 1'b0}) begin
         n_fail++;
         $display("FAIL oneshot_load: out/tc/busy/done got %0d/%b/%b/%b want 3/0/1/0", out, tc, busy, done);
      end
      load = 1'b0; en = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         eo = 4'(2 - i);
         n_checks++;
         if ({out, tc, busy, done} !== {eo, (i == 2), (i != 2), (i == 2)}) begin
            n_fail++;
            $display("FAIL oneshot_step%0d: out/tc/busy/done got %0d/%b/%b/%b want %0d/%b/%b/%b",
                     i, out, tc, busy, done, eo, (i == 2), (i != 2), (i == 2));
         end
      end
      // DONE persists and ignores en
      for (int i = 0; i < 2; i++) begin
         tick();
         n_checks++;
         if ({out, tc, busy, done} !== {4'd0, 1'b0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL oneshot_done_hold%0d: out/tc/busy/done got %0d/%b/%b/%b want 0/0/0/1", i, out, tc, busy, done);
         end
      end
   endtask

   task automatic test_reload();
      logic [3:0] eo;
      logic       et;
      load = 1'b1; init = 4'd2; en = 1'b0; reload_mode = 1'b1;
      tick();
      n_checks++;
      if ({out, tc, busy, done} !== {4'd2, 1'b0, 1'b1, 1'b0}) begin
         n_fail++;
         $display("FAIL reload_load_from_done: out/tc/busy/done got %0d/%b/%b/%b want 2/0/1/0", out, tc, busy, done);
      end
      load = 1'b0; en = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         eo = (i % 2 == 0) ? 4'd1 : 4'd2;
         et = (i % 2 == 1);
         n_checks++;
         if ({out, tc, busy, done} !== {eo, et, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL reload_step%0d: out/tc/busy/done got %0d/%b/%b/%b want %0d/%b/1/0",
                     i, out, tc, busy, done, eo, et);
         end
      end
   endtask

   task automatic test_reload_sampled_at_expiry();
      load = 1'b1; init = 4'd3; en = 1'b0; reload_mode = 1'b1;
      tick();
      load = 1'b0; en = 1'b1;
      tick();
      reload_mode = 1'b0;
      tick();
      n_checks++;
      if ({out, tc, busy, done} !== {4'd1, 1'b0, 1'b1, 1'b0}) begin
         n_fail++;
         $display("FAIL mode_change_midcount: out/tc/busy/done got %0d/%b/%b/%b want 1/0/1/0", out, tc, busy, done);
      end
      tick();
      n_checks++;
      if ({out, tc, busy, done} !== {4'd0, 1'b1, 1'b0, 1'b1}) begin
         n_fail++;
         $display("FAIL mode_sampled_expiry: out/tc/busy/done got %0d/%b/%b/%b want 0/1/0/1", out, tc, busy, done);
      end
   endtask

   task automatic test_enable_hold();
      logic       en_seq [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
      logic [3:0] exp_out[4] = '{4'd4, 4'd4, 4'd4, 4'd3};
      load = 1'b1; init = 4'd5; en = 1'b0; reload_mode = 1'b0;
      tick();
      n_checks++;
      if ({out, tc, busy, done} !== {4'd5, 1'b0, 1'b1, 1'b0}) begin
         n_fail++;
         $display("FAIL hold_load: out/tc/busy/done got %0d/%b/%b/%b want 5/0/1/0", out, tc, busy, done);
      end
      load = 1'b0;
      for (int i = 0; i < 4; i++) begin
         en = en_seq[i];
         tick();
         n_checks++;
         if ({out, tc, busy, done} !== {exp_out[i], 1'b0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL hold_step%0d: out/tc/busy/done got %0d/%b/%b/%b want %0d/0/1/0",
                     i, out, tc, busy, done, exp_out[i]);
         end
      end
   endtask

   task automatic test_reset_midcount();
      load = 1'b1; init = 4'd4; en = 1'b0; reload_mode = 1'b0;
      tick();
      load = 1'b0; en = 1'b1;
      tick();
      tick();
      n_checks++;
      if (out !== 4'd2) begin
         n_fail++;
         $display("FAIL abort_precount: out got %0d want 2", out);
      end
      reset = 1'b1;
      tick();
      n_checks++;
      if ({out, tc, busy, done} !== {4'd0, 1'b0, 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL abort_reset: out/tc/busy/done got %0d/%b/%b/%b want 0/0/0/0", out, tc, busy, done);
      end
      reset = 1'b0;
      tick();
      n_checks++;
      if ({out, tc, busy, done} !== {4'd0, 1'b0, 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL abort_idle_en: out/tc/busy/done got %0d/%b/%b/%b want 0/0/0/0", out, tc, busy, done);
      end
   endtask

   task automatic test_load_priority();
      load = 1'b1; init = 4'd2; en = 1'b0; reload_mode = 1'b0;
      tick();
      load = 1'b0; en = 1'b1;
      tick();
      n_checks++;
      if (out !== 4'd1) begin
         n_fail++;
         $display("FAIL prio_at_one: out got %0d want 1", out);
      end
      load = 1'b1; init = 4'd9;
      tick();
      n_checks++;
      if ({out, tc, busy, done} !== {4'd9, 1'b0, 1'b1, 1'b0}) begin
         n_fail++;
         $display("FAIL prio_load_wins: out/tc/busy/done got %0d/%b/%b/%b want 9/0/1/0", out, tc, busy, done);
      end
      init = 4'd0;
      tick();
      n_checks++;
      if ({out, tc, busy, done} !== {4'd0, 1'b0, 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL prio_load_zero: out/tc/busy/done got %0d/%b/%b/%b want 0/0/0/0", out, tc, busy, done);
      end
      load = 1'b0;
      tick();
      n_checks++;
      if ({out, tc, busy, done} !== {4'd0, 1'b0, 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL prio_idle_no_wrap: out/tc/busy/done got %0d/%b/%b/%b want 0/0/0/0", out, tc, busy, done);
      end
   endtask

   task automatic test_full_range();
      int         tc_count = 0;
      logic [3:0] eo;
      load = 1'b1; init = 4'd15; en = 1'b0; reload_mode = 1'b0;
      tick();
      n_checks++;
      if ({out, busy} !== {4'd15, 1'b1}) begin
         n_fail++;
         $display("FAIL full_load: out/busy got %0d/%b want 15/1", out, busy);
      end
      load = 1'b0; en = 1'b1;
      for (int i = 0; i < 18; i++) begin
         tick();
         eo = (i < 15) ? 4'(14 - i) : 4'd0;
         if (tc) tc_count++;
         n_checks++;
         if ({out, tc, done} !== {eo, (i == 14), (i >= 14)}) begin
            n_fail++;
            $display("FAIL full_step%0d: out/tc/done got %0d/%b/%b want %0d/%b/%b",
                     i, out, tc, done, eo, (i == 14), (i >= 14));
         end
      end
      n_checks++;
      if (tc_count !== 1) begin
         n_fail++;
         $display("FAIL full_tc_count: got %0d want 1", tc_count);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; load = 1'b0; init = '0; en = 1'b0; reload_mode = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      test_reset();
      test_oneshot();
      test_reload();
      test_reload_sampled_at_expiry();
      test_enable_hold();
      test_reset_midcount();
      test_load_priority();
      test_full_range();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
